// File: rtl/mac_ctrl_pkg.sv
// mac_ctrl_pkg: shared FSM state type and step-counter width helper for the MAC array sequencer
package mac_ctrl_pkg;

    typedef enum logic [1:0] {IDLE, CLEAR, RUN, DONE} state_t;

    // Step counter must hold k_len + lanes - 1 without wrapping.
    function automatic int t_width(input int k_w, input int lanes);
        return k_w + $clog2(lanes) + 1;
    endfunction

endpackage

// File: rtl/mac_lane_skew.sv
// mac_lane_skew: skewed operand-buffer address and zero-inject flag for one array edge lane
module mac_lane_skew
    import mac_ctrl_pkg::*;
#(
    parameter int OFFSET = 0,
    parameter int K_W    = 8,
    parameter int T_W    = t_width(8, 8)
) (
    input  logic [T_W-1:0] t,
    input  logic [K_W-1:0] k_len,
    input  logic           run,
    output logic [K_W-1:0] addr,
    output logic           zero
);

    logic [T_W-1:0] rel;

    always_comb begin
        rel  = t - T_W'(OFFSET);
        zero = !run || (t < T_W'(OFFSET)) || (rel >= T_W'(k_len));
        addr = zero ? '0 : rel[K_W-1:0];
    end

endmodule

// File: rtl/mac_array_ctrl.sv
// mac_array_ctrl: sequencer that clears, skews operand feeds into, and signals completion of a systolic MAC array
module mac_array_ctrl
    import mac_ctrl_pkg::*;
#(
    parameter int ROWS = 4,
    parameter int COLS = 4,
    parameter int K_W  = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [K_W-1:0]      k_len,
    output logic                busy,
    output logic                arr_clr,
    output logic [ROWS*K_W-1:0] a_addr,
    output logic [ROWS-1:0]     a_zero,
    output logic [COLS*K_W-1:0] w_addr,
    output logic [COLS-1:0]     w_zero,
    output logic                done
);

    localparam int T_W = t_width(K_W, ROWS + COLS);
    localparam logic [T_W-1:0] T_LAST = T_W'(ROWS + COLS - 2);

    state_t              state, state_nxt;
    logic [T_W-1:0]      t, t_nxt;
    logic [K_W-1:0]      kq;
    logic                run_nxt;
    logic [ROWS*K_W-1:0] a_addr_nxt;
    logic [ROWS-1:0]     a_zero_nxt;
    logic [COLS*K_W-1:0] w_addr_nxt;
    logic [COLS-1:0]     w_zero_nxt;

    always_comb begin
        state_nxt = state;
        t_nxt     = t;
        unique case (state)
            IDLE:  state_nxt = start ? CLEAR : IDLE;
            CLEAR: begin
                t_nxt     = '0;
                state_nxt = (kq == '0) ? DONE : RUN;
            end
            RUN: begin
                t_nxt     = t + 1'b1;
                state_nxt = (t == T_W'(kq) + T_LAST) ? DONE : RUN;
            end
            DONE:  state_nxt = IDLE;
        endcase
        run_nxt = (state_nxt == RUN);
    end

    // Lanes see next-cycle step so their outputs can be registered alongside the FSM.
    for (genvar r = 0; r < ROWS; r++) begin : g_row
        mac_lane_skew #(.OFFSET(r), .K_W(K_W), .T_W(T_W)) u_skew (
            .t(t_nxt), .k_len(kq), .run(run_nxt),
            .addr(a_addr_nxt[r*K_W +: K_W]), .zero(a_zero_nxt[r])
        );
    end

    for (genvar c = 0; c < COLS; c++) begin : g_col
        mac_lane_skew #(.OFFSET(c), .K_W(K_W), .T_W(T_W)) u_skew (
            .t(t_nxt), .k_len(kq), .run(run_nxt),
            .addr(w_addr_nxt[c*K_W +: K_W]), .zero(w_zero_nxt[c])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            t       <= '0;
            kq      <= '0;
            busy    <= 1'b0;
            arr_clr <= 1'b0;
            done    <= 1'b0;
            a_addr  <= '0;
            a_zero  <= '1;
            w_addr  <= '0;
            w_zero  <= '1;
        end else begin
            state   <= state_nxt;
            t       <= t_nxt;
            if (state == IDLE && start) kq <= k_len;
            busy    <= (state_nxt != IDLE);
            arr_clr <= (state_nxt == CLEAR);
            done    <= (state_nxt == DONE);
            a_addr  <= a_addr_nxt;
            a_zero  <= a_zero_nxt;
            w_addr  <= w_addr_nxt;
            w_zero  <= w_zero_nxt;
        end
    end

endmodule

// File: tb/tb_mac_array_ctrl.sv
// tb_mac_array_ctrl: directed self-checking bench for mac_array_ctrl with a behavioural 4x4 output-stationary array
module tb_mac_array_ctrl;

    localparam int ROWS = 4;
    localparam int COLS = 4;
    localparam int K_W  = 8;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                start = 1'b0;
    logic [K_W-1:0]      k_len = '0;
    logic                busy, arr_clr, done;
    logic [ROWS*K_W-1:0] a_addr;
    logic [ROWS-1:0]     a_zero;
    logic [COLS*K_W-1:0] w_addr;
    logic [COLS-1:0]     w_zero;

    int passes = 0;
    int fails  = 0;
    int checks = 0;
    int cyc    = 0;
    int done_cyc, ndone;

    logic [7:0]  abuf [ROWS][4];
    logic [7:0]  wbuf [4][COLS];
    logic [7:0]  ar   [ROWS][COLS];
    logic [7:0]  wr   [ROWS][COLS];
    logic [15:0] acc  [ROWS][COLS];

    mac_array_ctrl #(.ROWS(ROWS), .COLS(COLS), .K_W(K_W)) dut (
        .clk(clk), .rst(rst), .start(start), .k_len(k_len),
        .busy(busy), .arr_clr(arr_clr),
        .a_addr(a_addr), .a_zero(a_zero),
        .w_addr(w_addr), .w_zero(w_zero),
        .done(done)
    );

    always #5 clk = ~clk;

    // Output-stationary array: A flows right, W flows down, each PE accumulates its operand product.
    always @(posedge clk or posedge rst) begin
        if (rst || arr_clr) begin
            for (int r = 0; r < ROWS; r++)
                for (int c = 0; c < COLS; c++) begin
                    acc[r][c] <= '0;
                    ar[r][c]  <= '0;
                    wr[r][c]  <= '0;
                end
        end else begin
            for (int r = 0; r < ROWS; r++)
                for (int c = 0; c < COLS; c++) begin
                    acc[r][c] <= acc[r][c] + 16'(ar[r][c]) * 16'(wr[r][c]);
                    if (c == 0) ar[r][c] <= a_zero[r] ? 8'd0 : abuf[r][a_addr[r*K_W +: 2]];
                    else        ar[r][c] <= ar[r][c-1];
                    if (r == 0) wr[r][c] <= w_zero[c] ? 8'd0 : wbuf[w_addr[c*K_W +: 2]][c];
                    else        wr[r][c] <= wr[r-1][c];
                end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic go(input logic [K_W-1:0] k);
        k_len = k;
        start = 1'b1;
        cyc   = 0;
        tick();
        start = 1'b0;
    endtask

    initial begin
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                abuf[r][c] = (r == c) ? 8'd1 : 8'd0;
                wbuf[r][c] = 8'(r * 4 + c + 1);
            end

        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rst_busy", busy, 0);
        chk("rst_clr", arr_clr, 0);
        chk("rst_done", done, 0);
        chk("rst_azero", a_zero, 4'hF);
        chk("rst_wzero", w_zero, 4'hF);
        chk("rst_aaddr", a_addr, 0);
        chk("rst_waddr", w_addr, 0);

        // k_len=3 timing and lane skew
        go(3);
        chk("t1_clr", arr_clr, 1);
        chk("t1_busy1", busy, 1);
        chk("t1_zero_clr", a_zero, 4'hF);
        while (cyc < 13) begin
            tick();
            chk("t1_busy", busy, 32'(cyc <= 12));
            chk("t1_done", done, 32'(cyc == 12));
            chk("t1_noclr", arr_clr, 0);
            if (cyc == 2) begin
                chk("t1_t0_azero", a_zero, 4'b1110);
                chk("t1_t0_wzero", w_zero, 4'b1110);
                chk("t1_t0_a0", a_addr[7:0], 0);
            end
            if (cyc == 3) begin
                chk("t1_t1_a0", a_addr[7:0], 1);
                chk("t1_t1_a1", a_addr[15:8], 0);
            end
            if (cyc == 6) begin
                chk("t1_t4_azero", a_zero, 4'b0011);
                chk("t1_t4_a3", a_addr[31:24], 1);
                chk("t1_t4_w3", w_addr[31:24], 1);
                chk("t1_t4_a0", a_addr[7:0], 0);
            end
            if (cyc == 8) begin
                chk("t1_t6_azero", a_zero, 4'hF);
                chk("t1_t6_wzero", w_zero, 4'hF);
            end
        end

        // k_len=0 with start pulses while busy and in the DONE cycle
        go(0);
        chk("t4_clr", arr_clr, 1);
        chk("t4_zero1", a_zero, 4'hF);
        start = 1'b1;
        tick();
        chk("t4_done", done, 1);
        chk("t4_busy", busy, 1);
        chk("t4_zero2", a_zero, 4'hF);
        chk("t4_wzero2", w_zero, 4'hF);
        tick();
        start = 1'b0;
        chk("t4_idle_busy", busy, 0);
        chk("t4_idle_clr", arr_clr, 0);
        chk("t4_idle_done", done, 0);
        tick();
        chk("t4_still_idle", busy, 0);

        // Full array: A = I4, W = 1..16, so every sout equals the matching W entry
        go(4);
        while (!done && cyc < 40) tick();
        chk("t3_done_cyc", cyc, 13);
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                chk($sformatf("t3_sout_%0d_%0d", r, c), acc[r][c], r * 4 + c + 1);
        repeat (5) tick();
        chk("t3_idle", busy, 0);
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                chk($sformatf("t3_hold_%0d_%0d", r, c), acc[r][c], r * 4 + c + 1);

        // Async reset mid-tile at t=5
        go(3);
        while (cyc < 7) tick();
        chk("t5_busy_pre", busy, 1);
        #2 rst = 1'b1;
        #1;
        chk("t5_busy", busy, 0);
        chk("t5_azero", a_zero, 4'hF);
        chk("t5_wzero", w_zero, 4'hF);
        chk("t5_aaddr", a_addr, 0);
        chk("t5_waddr", w_addr, 0);
        chk("t5_done", done, 0);
        @(negedge clk);
        rst = 1'b0;
        ndone = 0;
        repeat (10) begin
            tick();
            if (done) ndone++;
        end
        chk("t5_no_done", ndone, 0);
        go(3);
        while (cyc < 13) begin
            tick();
            chk("t5_re_done", done, 32'(cyc == 12));
            chk("t5_re_busy", busy, 32'(cyc <= 12));
        end

        // Maximum depth: no counter wrap
        go(255);
        done_cyc = -1;
        ndone = 0;
        while (cyc < 280) begin
            tick();
            if (done) begin
                ndone++;
                done_cyc = cyc;
            end
            if (cyc == 259) begin
                chk("t6_a3", a_addr[31:24], 254);
                chk("t6_azero3", a_zero[3], 0);
            end
        end
        chk("t6_done_cyc", done_cyc, 264);
        chk("t6_ndone", ndone, 1);
        chk("t6_idle", busy, 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
